alu_issue_unit: RTL and testbench
=================================

Name: alu_issue_unit

Overview:
- Upstream sequencer for the 8-bit registered ALU.
- Accepts 16-bit instructions over a valid/ready handshake and holds a 4x8 register file.
- For ALU instructions: reads two operands, drives them with the 4-bit select to the ALU, waits out the ALU's register latency, and writes the ALU result back.
- Load-immediate instructions write the register file directly; one instruction is in flight at a time.

Parameters:
- DW, 8, data width; matches the ALU operand and result width.
- AW, 2, register address width; register file depth is 2**AW = 4.
- ALU_LAT, 1, ALU output register latency in cycles; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_instr  in  16  instruction word:
  - [15] = 1: load-immediate.
  - [13:12] rd.
  - [11:10] ra.
  - [9:8] rb.
  - [7:0] imm when [15] = 1.
  - [3:0] ALU select when [15] = 0.
  - [14] ignored.
- in_ready  out  1  unit can accept an instruction.
- alu_a  out  DW  ALU operand A, registered.
- alu_b  out  DW  ALU operand B, registered.
- alu_s  out  4  ALU function select, registered.
- alu_result  in  DW  registered ALU output.
- wb_valid  out  1  register-file write occurring this cycle.
- wb_addr  out  AW  write address.
- wb_data  out  DW  write data.
- busy  out  1  instruction in flight (state != IDLE).
- dbg_addr  in  AW  debug read address.
- dbg_data  out  DW  combinational read of rf[dbg_addr].

Behaviour:
- Reset (synchronous, any state):
  - state <= IDLE.
  - all rf entries, alu_a, alu_b, alu_s, latched rd/imm and the latency counter <= 0.
  - Any in-flight instruction is discarded with no writeback.
  - in_ready = 0 while reset is high; wb_valid = 0 in the cycle after reset.
- States:
  - IDLE:
    - in_ready = 1.
    - Accept on in_valid & in_ready.
    - ALU instruction: alu_a <= rf[ra], alu_b <= rf[rb], alu_s <= op, rd latched, counter <= ALU_LAT, next EXEC.
    - Load-immediate: rd and imm latched, next WB; alu_* unchanged.
  - EXEC:
    - in_ready = 0; alu_a/alu_b/alu_s held stable.
    - Counter decrements each cycle; when it reaches 1, next WB. EXEC lasts exactly ALU_LAT cycles.
  - WB:
    - wb_valid = 1, wb_addr = latched rd.
    - wb_data = alu_result (ALU instruction) or imm (load-immediate).
    - rf[rd] <= wb_data at the end of the cycle; next IDLE.
- Latency:
  - ALU instruction: accept cycle T, operands valid T+1 through T+ALU_LAT, WB at T+ALU_LAT+1, in_ready again at T+ALU_LAT+2.
  - Load-immediate: WB at T+1, in_ready at T+2.
- Hazards:
  - A single instruction in flight plus write-before-next-accept removes RAW hazards.
  - An instruction accepted right after a WB reads the updated value.
- Register aliasing:
  - ra == rb is legal; both operands read the same register.
  - rd may equal ra or rb; the write lands after the operand read.
- dbg_data shows a write starting the cycle after WB; in the WB cycle it shows the old value.
- in_valid while in_ready = 0: ignored; the source must hold the instruction until accepted.
- wb_addr and wb_data are 0 when wb_valid = 0.

Test Plan:
- Bench ALU model returns A+B (s=0000) registered one cycle.
- 1. Reset, then dbg_addr sweeps 0..3 -> dbg_data = 0x00 for every address; in_ready = 1; busy = 0; alu_a/alu_b/alu_s = 0.
- 2. Load-immediate r1=0x35 (instr 0x9035) accepted at cycle T -> wb_valid at T+1 with wb_addr=1, wb_data=0x35; dbg r1 = 0x35 at T+2; in_ready at T+2.
- 3. Load r1=0x35 and r2=0x0A, then ADD r3=r1+r2 (instr 0x3600) -> alu_a=0x35, alu_b=0x0A, alu_s=0 at T+1; wb_data=0x3F to r3 at T+2; in_ready at T+3.
- 4. Back-to-back dependent ops, with in_valid held high continuously:
  - r0=0xFF by load-immediate.
  - ADD r0=r0+r0 -> wb_data 0xFE (8-bit wrap).
  - ADD r1=r0+r0 -> alu_a=0xFE, i.e. it reads the updated r0.
  - No instruction is lost or duplicated.
- 5. Reset asserted during EXEC of an ADD -> no wb_valid; all registers read 0; state IDLE one cycle after reset.
- 6. ALU_LAT=3 build -> alu_* held stable for 3 cycles; WB at T+4; held-high in_valid is not accepted before T+5.

Source files
------------

// File: rtl/alu_issue_unit.sv
// Issue sequencer for the registered 8-bit ALU: owns a small register file,
// issues one instruction at a time and writes back ALU or immediate results.
module alu_issue_unit #(
  parameter int DW      = 8,
  parameter int AW      = 2,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [15:0]   in_instr,
  output logic          in_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_s,
  input  logic [DW-1:0] alu_result,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          busy,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int NREG = 2 ** AW;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   rf_q [NREG];
  logic [DW-1:0]   rf_d [NREG];
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [3:0]      alu_s_q, alu_s_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [DW-1:0]   imm_q, imm_d;
  logic            li_q, li_d;
  logic [2:0]      cnt_q, cnt_d;

  logic [AW-1:0]   ra, rb;
  logic            unused_instr_bit;

  assign ra               = AW'(in_instr[11:10]);
  assign rb               = AW'(in_instr[9:8]);
  assign unused_instr_bit = in_instr[14];

  always_comb begin
    state_d  = state_q;
    rf_d     = rf_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_s_d  = alu_s_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    li_d     = li_q;
    cnt_d    = cnt_q;
    in_ready = 1'b0;
    wb_valid = 1'b0;
    wb_addr  = '0;
    wb_data  = '0;

    case (state_q)
      IDLE: begin
        in_ready = ~reset;
        if (in_valid) begin
          rd_d = AW'(in_instr[13:12]);
          if (in_instr[15]) begin
            li_d    = 1'b1;
            imm_d   = DW'(in_instr[7:0]);
            state_d = WB;
          end else begin
            li_d    = 1'b0;
            alu_a_d = rf_q[ra];
            alu_b_d = rf_q[rb];
            alu_s_d = in_instr[3:0];
            cnt_d   = 3'(ALU_LAT);
            state_d = EXEC;
          end
        end
      end

      // Operands stay frozen while the ALU pipeline drains.
      EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = WB;
      end

      WB: begin
        wb_valid      = 1'b1;
        wb_addr       = rd_q;
        wb_data       = li_q ? imm_q : alu_result;
        rf_d[rd_q]    = wb_data;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      alu_a_q <= '0;
      alu_b_q <= '0;
      alu_s_q <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      li_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      alu_a_q <= alu_a_d;
      alu_b_q <= alu_b_d;
      alu_s_q <= alu_s_d;
      rd_q    <= rd_d;
      imm_q   <= imm_d;
      li_q    <= li_d;
      cnt_q   <= cnt_d;
    end
  end

  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_s    = alu_s_q;
  assign busy     = (state_q != IDLE);
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: one instance with ALU_LAT=1 and one with ALU_LAT=3,
// each driving a bench-side registered ALU model (s=0 add, otherwise xor).
module tb_alu_issue_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, wb_valid, busy;
  logic [15:0] in_instr;
  logic [7:0]  alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic [3:0]  alu_s;
  logic [1:0]  wb_addr, dbg_addr;

  logic        in_valid3, in_ready3, wb_valid3, busy3;
  logic [15:0] in_instr3;
  logic [7:0]  alu_a3, alu_b3, alu_result3, wb_data3, dbg_data3;
  logic [3:0]  alu_s3;
  logic [1:0]  wb_addr3, dbg_addr3;

  alu_issue_unit #(.DW(8), .AW(2), .ALU_LAT(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_result(alu_result), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu_issue_unit #(.DW(8), .AW(2), .ALU_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid3), .in_instr(in_instr3),
    .in_ready(in_ready3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_s(alu_s3),
    .alu_result(alu_result3), .wb_valid(wb_valid3), .wb_addr(wb_addr3),
    .wb_data(wb_data3), .busy(busy3), .dbg_addr(dbg_addr3), .dbg_data(dbg_data3)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    return (s == 4'd0) ? 8'(a + b) : (a ^ b);
  endfunction

  logic [7:0] p1;
  logic [7:0] p3 [3];
  always @(posedge clk) begin
    p1    <= alu_f(alu_a, alu_b, alu_s);
    p3[0] <= alu_f(alu_a3, alu_b3, alu_s3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign alu_result  = p1;
  assign alu_result3 = p3[2];

  logic [9:0] q1 [$];
  logic [9:0] q3 [$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  sb_on = 1'b0;

  typedef struct {
    logic [15:0] instr;
    logic [1:0]  addr;
    logic [7:0]  data;
    logic [7:0]  a;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic v, input logic [1:0] a,
                          input logic [7:0] d, input bit is3);
    logic [9:0] e;
    if (v) begin
      if ((is3 ? q3.size() : q1.size()) == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL %s_unexpected: got wb addr %0d data %h expected no writeback", tag, a, d);
      end else begin
        e = is3 ? q3.pop_front() : q1.pop_front();
        chk({tag, "_addr"}, 16'(a), 16'(e[9:8]));
        chk({tag, "_data"}, 16'(d), 16'(e[7:0]));
      end
    end else begin
      chk({tag, "_idle_zero"}, 16'({a, d}), 16'h0000);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (sb_on) begin
      sb_check("wb1", wb_valid, wb_addr, wb_data, 1'b0);
      sb_check("wb3", wb_valid3, wb_addr3, wb_data3, 1'b1);
    end
  endtask

  // Holds in_valid high until accepted; returns in the cycle after acceptance.
  task automatic issue1(input logic [15:0] instr, input logic [9:0] exp);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_instr = instr;
    q1.push_back(exp);
    while (!in_ready && budget < 20) begin
      step();
      budget++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 20 cycles");
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t       vecs [9];
    logic [7:0] exp_rf [4];

    vecs[0] = '{16'h80FF, 2'd0, 8'hFF, 8'h00};
    vecs[1] = '{16'h0000, 2'd0, 8'hFE, 8'hFF};
    vecs[2] = '{16'h1000, 2'd1, 8'hFC, 8'hFE};
    vecs[3] = '{16'hE080, 2'd2, 8'h80, 8'h00};
    vecs[4] = '{16'h3A00, 2'd3, 8'h00, 8'h80};
    vecs[5] = '{16'h2600, 2'd2, 8'h7C, 8'hFC};
    vecs[6] = '{16'h0601, 2'd0, 8'h80, 8'hFC};
    vecs[7] = '{16'hB05A, 2'd3, 8'h5A, 8'h00};
    vecs[8] = '{16'h1C00, 2'd1, 8'hDA, 8'h5A};
    exp_rf  = '{8'h80, 8'hDA, 8'h7C, 8'h5A};

    reset = 1'b1; in_valid = 1'b0; in_instr = '0; dbg_addr = '0;
    in_valid3 = 1'b0; in_instr3 = '0; dbg_addr3 = '0;
    repeat (2) @(negedge clk);
    chk("in_ready_in_reset", 16'(in_ready), 16'h0);
    reset = 1'b0;
    sb_on = 1'b1;
    step();

    // Reset state
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 chk("reset_rf", 16'(dbg_data), 16'h00);
    end
    chk("reset_in_ready", 16'(in_ready), 16'h1);
    chk("reset_busy", 16'(busy), 16'h0);
    chk("reset_alu_abs", 16'({alu_a, alu_b} ^ {4'h0, alu_s, 8'h00}), 16'h0000);
    chk("reset_alu_s", 16'(alu_s), 16'h0);

    // Load-immediate r1 = 0x35
    in_valid = 1'b1; in_instr = 16'h9035; q1.push_back({2'd1, 8'h35});
    step();
    in_valid = 1'b0; dbg_addr = 2'd1;
    #1;
    chk("li_wb_valid", 16'(wb_valid), 16'h1);
    chk("li_in_ready_t1", 16'(in_ready), 16'h0);
    chk("li_dbg_old", 16'(dbg_data), 16'h00);
    step();
    chk("li_dbg_new", 16'(dbg_data), 16'h35);
    chk("li_in_ready_t2", 16'(in_ready), 16'h1);

    // Load r2 then ADD r3 = r1 + r2
    issue1(16'hA00A, {2'd2, 8'h0A});
    in_valid = 1'b0;
    step();
    in_valid = 1'b1; in_instr = 16'h3600; q1.push_back({2'd3, 8'h3F});
    step();
    in_valid = 1'b0;
    chk("add_alu_a", 16'(alu_a), 16'h35);
    chk("add_alu_b", 16'(alu_b), 16'h0A);
    chk("add_alu_s", 16'(alu_s), 16'h0);
    chk("add_in_ready_t1", 16'(in_ready), 16'h0);
    chk("add_wb_t1", 16'(wb_valid), 16'h0);
    step();
    chk("add_wb_valid_t2", 16'(wb_valid), 16'h1);
    chk("add_in_ready_t2", 16'(in_ready), 16'h0);
    step();
    chk("add_in_ready_t3", 16'(in_ready), 16'h1);
    dbg_addr = 2'd3;
    #1 chk("add_dbg_r3", 16'(dbg_data), 16'h3F);

    // Back-to-back table with in_valid held high throughout
    for (int i = 0; i < 9; i++) begin
      issue1(vecs[i].instr, {vecs[i].addr, vecs[i].data});
      if (!vecs[i].instr[15]) chk($sformatf("vec%0d_alu_a", i), 16'(alu_a), 16'(vecs[i].a));
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("sb1_drained", 16'(q1.size()), 16'h0);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 chk($sformatf("table_rf%0d", i), 16'(dbg_data), 16'(exp_rf[i]));
    end

    // Reset during EXEC discards the in-flight ADD
    in_valid = 1'b1; in_instr = 16'h3400;
    step();
    in_valid = 1'b0;
    chk("rst_busy_exec", 16'(busy), 16'h1);
    reset = 1'b1;
    step();
    chk("rst_in_ready_hi", 16'(in_ready), 16'h0);
    chk("rst_busy_hi", 16'(busy), 16'h0);
    reset = 1'b0;
    step();
    chk("rst_wb_after", 16'(wb_valid), 16'h0);
    chk("rst_in_ready_after", 16'(in_ready), 16'h1);
    chk("rst_alu_a", 16'(alu_a), 16'h00);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1 chk($sformatf("rst_rf%0d", i), 16'(dbg_data), 16'h00);
    end

    // ALU_LAT = 3 instance
    in_valid3 = 1'b1; in_instr3 = 16'h9035; q3.push_back({2'd1, 8'h35});
    step();
    in_valid3 = 1'b0;
    step();
    chk("l3_in_ready_idle", 16'(in_ready3), 16'h1);
    in_valid3 = 1'b1; in_instr3 = 16'h3500; q3.push_back({2'd3, 8'h6A});
    step();
    in_instr3 = 16'hA011;
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("l3_alu_a_t%0d", k), 16'(alu_a3), 16'h35);
      chk($sformatf("l3_alu_b_t%0d", k), 16'(alu_b3), 16'h35);
      chk($sformatf("l3_alu_s_t%0d", k), 16'(alu_s3), 16'h0);
      chk($sformatf("l3_in_ready_t%0d", k), 16'(in_ready3), 16'h0);
      chk($sformatf("l3_wb_t%0d", k), 16'(wb_valid3), 16'h0);
      step();
    end
    chk("l3_wb_valid_t4", 16'(wb_valid3), 16'h1);
    chk("l3_wb_data_t4", 16'(wb_data3), 16'h6A);
    chk("l3_in_ready_t4", 16'(in_ready3), 16'h0);
    q3.push_back({2'd2, 8'h11});
    step();
    chk("l3_in_ready_t5", 16'(in_ready3), 16'h1);
    chk("l3_busy_t5", 16'(busy3), 16'h0);
    step();
    in_valid3 = 1'b0;
    chk("l3_li_wb_t6", 16'(wb_valid3), 16'h1);
    repeat (2) step();
    chk("sb3_drained", 16'(q3.size()), 16'h0);
    dbg_addr3 = 2'd3;
    #1 chk("l3_dbg_r3", 16'(dbg_data3), 16'h6A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
